// File: rtl/antirrebote_up_down.sv
// Debounced up/down push-button front end producing one-cycle count pulses.
// Ports: clk, reset (sync, active-low), btn_up/btn_down (raw, bouncing),
//        up_p/down_p (registered one-cycle pulses), en_p = up_p | down_p.
// Optional: define AUTOREPEAT_EN to compile in the hold-to-repeat FSM
//           (REP_DELAY to first repeat, then one pulse every REP_PERIOD).
module antirrebote_up_down #(
    parameter int DEB_MAX    = 1000000,
    parameter int REP_DELAY  = 50000000,
    parameter int REP_PERIOD = 20000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    output logic up_p,
    output logic down_p,
    output logic en_p
);

    localparam int CW = (DEB_MAX > 1) ? $clog2(DEB_MAX) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(DEB_MAX - 1);

    if (DEB_MAX < 1 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_bad_cfg
        $error("antirrebote_up_down: parameters must be >= 1");
    end

    // Bit 0 is the up button, bit 1 the down button.
    logic [1:0]         sync_a;
    logic [1:0]         sync_b;
    logic [1:0]         level;
    logic [1:0]         level_q;
    logic [1:0][CW-1:0] cnt;

    logic rise_up;
    logic rise_down;
    logic next_up;
    logic next_down;

    // Two-flop synchronizer, then a per-button stability counter that
    // restarts whenever the input agrees with the accepted level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_a  <= '0;
            sync_b  <= '0;
            level   <= '0;
            level_q <= '0;
            cnt     <= '0;
        end else begin
            sync_a  <= {btn_down, btn_up};
            sync_b  <= sync_a;
            level_q <= level;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_TOP) begin
                    level[i] <= ~level[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press only counts while the other button is released.
    assign rise_up   = level[0] & ~level_q[0] & ~level[1];
    assign rise_down = level[1] & ~level_q[1] & ~level[0];

`ifdef AUTOREPEAT_EN
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] HOLD_WAIT = 2'd1;
    localparam logic [1:0] REPEAT    = 2'd2;

    localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DELAY_TOP  = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_TOP = RW'(REP_PERIOD - 1);

    logic [1:0]    state;
    logic          sel;
    logic [RW-1:0] rcnt;
    logic          held;
    logic          fire;

    // sel = 0: up latched, sel = 1: down latched.
    assign held = sel ? (level[1] & ~level[0])
                      : (level[0] & ~level[1]);

    always_comb begin
        fire = 1'b0;
        if (held) begin
            if (state == HOLD_WAIT) begin
                fire = (rcnt == DELAY_TOP);
            end else if (state == REPEAT) begin
                fire = (rcnt == PERIOD_TOP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            sel   <= 1'b0;
            rcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise_up | rise_down) begin
                        state <= HOLD_WAIT;
                        sel   <= rise_down;
                        rcnt  <= '0;
                    end
                end
                HOLD_WAIT, REPEAT: begin
                    if (!held) begin
                        state <= IDLE;
                    end else if (fire) begin
                        state <= REPEAT;
                        rcnt  <= '0;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign next_up   = rise_up   | (fire & ~sel);
    assign next_down = rise_down | (fire & sel);
`else
    assign next_up   = rise_up;
    assign next_down = rise_down;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            up_p   <= 1'b0;
            down_p <= 1'b0;
            en_p   <= 1'b0;
        end else begin
            up_p   <= next_up;
            down_p <= next_down;
            en_p   <= next_up | next_down;
        end
    end

endmodule

// File: tb/tb_antirrebote_up_down.sv
// Bench for antirrebote_up_down: vector table, corner sequences and a
// random run checked against a behavioural model (DEB_MAX=4, 10, 5).
module tb_antirrebote_up_down;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;
    localparam int WIN = 40;

    logic clk = 1'b0;
    logic reset;
    logic btn_up;
    logic btn_down;
    logic up_p;
    logic down_p;
    logic en_p;

    always #5 clk = ~clk;

    antirrebote_up_down #(
        .DEB_MAX(DEB),
        .REP_DELAY(RD),
        .REP_PERIOD(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .up_p(up_p),
        .down_p(down_p),
        .en_p(en_p)
    );

    int checks = 0;
    int fails  = 0;
    bit chk_on = 1'b0;

    task automatic chk_b(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", n, a, e, $time);
        end
    endtask

    task automatic chk_i(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // A level is accepted once the synchronized input has disagreed with
    // it for DEB consecutive samples (sliding window of samples).
    bit m_lvl [2];
    bit m_lq  [2];
    bit m_s0  [2];
    bit m_s1  [2];
    bit wq_u [$];
    bit wq_d [$];
    bit e_up;
    bit e_dn;
    int edge_n = 0;
`ifdef AUTOREPEAT_EN
    bit m_act;
    int m_btn;
    int m_next;
`endif

    function automatic bit all_diff(input bit q [$], input bit l);
        if (q.size() < DEB) return 1'b0;
        foreach (q[i]) if (q[i] == l) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        bit raw [2];
        bit sv  [2];
        bit pr  [2];
        bit rp  [2];
        bit lo  [2];
        edge_n++;
        raw[0] = btn_up;
        raw[1] = btn_down;
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                m_lvl[b] = 1'b0;
                m_lq[b]  = 1'b0;
                m_s0[b]  = 1'b0;
                m_s1[b]  = 1'b0;
            end
            wq_u.delete();
            wq_d.delete();
            e_up = 1'b0;
            e_dn = 1'b0;
`ifdef AUTOREPEAT_EN
            m_act = 1'b0;
`endif
        end else begin
            for (int b = 0; b < 2; b++) begin
                pr[b] = m_lvl[b] && !m_lq[b] && !m_lvl[1-b];
                rp[b] = 1'b0;
            end
`ifdef AUTOREPEAT_EN
            if (m_act) begin
                if (!(m_lvl[m_btn] && !m_lvl[1-m_btn])) begin
                    m_act = 1'b0;
                end else if (edge_n == m_next) begin
                    rp[m_btn] = 1'b1;
                    m_next += RP;
                end
            end else if (pr[0] || pr[1]) begin
                m_act  = 1'b1;
                m_btn  = pr[1] ? 1 : 0;
                m_next = edge_n + RD;
            end
`endif
            for (int b = 0; b < 2; b++) begin
                sv[b]   = m_s1[b];
                m_s1[b] = m_s0[b];
                m_s0[b] = raw[b];
                lo[b]   = m_lvl[b];
            end
            wq_u.push_back(sv[0]);
            if (wq_u.size() > DEB) void'(wq_u.pop_front());
            if (all_diff(wq_u, m_lvl[0])) begin
                m_lvl[0] = !m_lvl[0];
                wq_u.delete();
            end
            wq_d.push_back(sv[1]);
            if (wq_d.size() > DEB) void'(wq_d.pop_front());
            if (all_diff(wq_d, m_lvl[1])) begin
                m_lvl[1] = !m_lvl[1];
                wq_d.delete();
            end
            m_lq[0] = lo[0];
            m_lq[1] = lo[1];
            e_up = pr[0] || rp[0];
            e_dn = pr[1] || rp[1];
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk_b("model_up", up_p, e_up);
            chk_b("model_down", down_p, e_dn);
            chk_b("model_en", en_p, e_up | e_dn);
            chk_b("exclusive", up_p & down_p, 1'b0);
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        bit up;
        bit dn;
        int hold;
        int n_up;
        int n_dn;
        int first;
    } vec_t;

    vec_t tv [7];
    int   nu, nd, ne, first;
    int   offs [$];
    int   exp_o [7] = '{0, 10, 15, 20, 25, 30, 35};
    bit   tgt [2];
    int   bnc [2];
    int   rst_cnt;

    initial begin
        tv[0] = '{1'b1, 1'b0, 10, 1, 0, 7};
        tv[1] = '{1'b0, 1'b1, 10, 0, 1, 7};
        tv[2] = '{1'b1, 1'b1, 10, 0, 0, -1};
        tv[3] = '{1'b0, 1'b0, 10, 0, 0, -1};
        tv[4] = '{1'b1, 1'b0, 3, 0, 0, -1};
        tv[5] = '{1'b1, 1'b0, 4, 1, 0, 7};
        tv[6] = '{1'b1, 1'b1, 30, 0, 0, -1};

        reset    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (3) @(negedge clk);
        chk_b("rst_up", up_p, 1'b0);
        chk_b("rst_down", down_p, 1'b0);
        chk_b("rst_en", en_p, 1'b0);
        chk_on = 1'b1;
        reset  = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            nu = 0;
            nd = 0;
            ne = 0;
            first = -1;
            btn_up   = tv[v].up;
            btn_down = tv[v].dn;
            for (int k = 1; k <= WIN; k++) begin
                @(negedge clk);
                if (up_p) nu++;
                if (down_p) nd++;
                if (en_p) ne++;
                if ((up_p || down_p) && first < 0) first = k;
                if (k == tv[v].hold) begin
                    btn_up   = 1'b0;
                    btn_down = 1'b0;
                end
            end
            chk_i($sformatf("vec%0d_nup", v), nu, tv[v].n_up);
            chk_i($sformatf("vec%0d_ndn", v), nd, tv[v].n_dn);
            chk_i($sformatf("vec%0d_nen", v), ne, tv[v].n_up + tv[v].n_dn);
            chk_i($sformatf("vec%0d_first", v), first, tv[v].first);
        end

        // down button chattering every two cycles: never accepted
        ne = 0;
        btn_down = 1'b1;
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            if (up_p || down_p || en_p) ne++;
            btn_down = (k < 20) ? (((k / 2) % 2) == 0) : 1'b0;
        end
        chk_i("bounce_pulses", ne, 0);

        // reset mid-debounce with the button still held
        ne = 0;
        btn_up = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (up_p || down_p || en_p) ne++;
        end
        chk_i("rst_abort_pulses", ne, 0);
        reset = 1'b1;
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (up_p && first < 0) begin
                first = k;
                btn_up = 1'b0;
            end
        end
        chk_i("rst_redebounce_edge", first, 7);
        btn_up = 1'b0;
        repeat (15) @(negedge clk);

`ifdef AUTOREPEAT_EN
        // held press: first pulse, repeat after RD, then every RP
        offs.delete();
        first = -1;
        nd = 0;
        btn_up = 1'b1;
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            if (down_p) nd++;
            if (up_p) begin
                if (first < 0) first = k;
                offs.push_back(k - first);
            end
            if (first > 0 && k == first + 32) btn_up = 1'b0;
        end
        chk_i("rep_first", first, 7);
        chk_i("rep_count", offs.size(), 7);
        chk_i("rep_down", nd, 0);
        for (int i = 0; i < 7; i++) begin
            if (i < offs.size()) chk_i($sformatf("rep_off%0d", i), offs[i], exp_o[i]);
        end
`else
        // long hold yields a single pulse
        nu = 0;
        nd = 0;
        btn_down = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (up_p) nu++;
            if (down_p) nd++;
            if (k == 100) btn_down = 1'b0;
        end
        chk_i("hold_down_pulses", nd, 1);
        chk_i("hold_up_pulses", nu, 0);
`endif
        repeat (10) @(negedge clk);

        // random bouncing presses with occasional resets
        tgt[0] = 1'b0;
        tgt[1] = 1'b0;
        bnc[0] = 0;
        bnc[1] = 0;
        rst_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(0, 29) == 0) begin
                    tgt[b] = !tgt[b];
                    bnc[b] = int'($urandom_range(0, 7));
                end
            end
            btn_up   = (bnc[0] > 0) ? 1'($urandom_range(0, 1)) : tgt[0];
            btn_down = (bnc[1] > 0) ? 1'($urandom_range(0, 1)) : tgt[1];
            if (bnc[0] > 0) bnc[0]--;
            if (bnc[1] > 0) bnc[1]--;
            if (rst_cnt == 0 && $urandom_range(0, 499) == 0) begin
                rst_cnt = int'($urandom_range(1, 3));
            end
            reset = (rst_cnt > 0) ? 1'b0 : 1'b1;
            if (rst_cnt > 0) rst_cnt--;
        end
        reset = 1'b1;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
